uart_rx: RTL and testbench
==========================

# uart_rx

Receive half of the 8N1 UART link: recovers bytes from the asynchronous serial line `rx` and presents each one as a single-cycle `valid` pulse with parallel `data`. It sits between the board pin and the byte consumer. It mirrors the transmitter's framing:
- idle high;
- one low start bit;
- 8 data bits, LSB first;
- one high stop bit.

Each bit lasts `CLKS_PER_BIT` clocks, and every bit is sampled at its middle.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per serial bit. Legal range 4 to 65535. Counter width is `$clog2(CLKS_PER_BIT)`.
- `clk`  input  1  the single clock. All logic is on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx`  input  1  raw serial line, asynchronous to `clk`. Idle level is 1.
- `data`  output  8  last good byte. Holds its value until the next `valid`.
- `valid`  output  1  one-cycle pulse when a byte is accepted.
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled as 0.
- `parity_err`  output  1  one-cycle pulse on a parity mismatch. Tied 0 without the macro.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- `rx` goes through a 2-flop synchronizer. Both flops reset to 1. The second flop's output is `rx_s`.
- Definitions:
  - N = `CLKS_PER_BIT`.
  - H = floor(N/2).
  - `cnt` is the bit-timing counter. It is cleared on every state change.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: when `rx_s`==0, go to START.
- START: when `cnt`==H-1, sample `rx_s`.
  - If 0: go to DATA with bit index 0.
  - If 1: false start (glitch); return to IDLE with no output.
- DATA: when `cnt`==N-1, sample `rx_s` into shift-register bit [index] (LSB first) and increment the index.
  - After index 7 is sampled, go to PARITY if the macro is defined, otherwise to STOP.
- PARITY: when `cnt`==N-1, sample the parity bit and go to STOP.
- STOP: when `cnt`==N-1, sample `rx_s`.
  - If 1: load `data` from the shift register, pulse `valid`, pulse `parity_err` if a mismatch was recorded, then go to IDLE.
  - If 0: pulse `frame_err`, leave `data` unchanged, no `valid`, go to BREAK.
- BREAK: wait for `rx_s`==1, then go to IDLE. This stops a held-low line from producing repeated frames.
- A parity mismatch does not suppress the byte. `valid` and `parity_err` pulse on the same cycle.
- A frame error takes priority: on a bad stop bit, `parity_err` stays 0 and only `frame_err` pulses.
- Reset values: state IDLE, `data`=8'h00, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, `cnt`=0, shift register 0.
- Reset mid-frame abandons the partial byte. The next falling edge after `rst` deasserts starts a fresh frame.

## Timing
- Let E0 be the first edge on which IDLE sees `rx_s`==0. That is 2 to 3 clocks after the pin falls, due to the synchronizer.
- Sample edges:
  - start bit: E0+H;
  - data bit i: E0+H+(i+1)·N;
  - parity bit: E0+H+9N;
  - stop bit: E0+H+9N without the macro, E0+H+10N with it.
- The outputs (`data`, `valid`, `frame_err`, `parity_err`) are registered on the stop-sample edge and are visible for exactly the following cycle.
- The block is back in IDLE on the stop-sample edge, i.e. mid-stop-bit. A start bit arriving right after the nominal stop bit is therefore accepted with no lost frame.
- `busy` rises the cycle after E0 and falls the cycle after the stop sample, or after BREAK exit.
- No backpressure: the consumer must take `data` on `valid`. The next byte overwrites it no earlier than 9N clocks later.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - frame gains an even-parity bit after bit 7, with the parity bit equal to the XOR of the 8 data bits;
  - PARITY state is present;
  - `parity_err` is driven.
- Not defined:
  - 8N1 framing;
  - no PARITY state;
  - `parity_err` tied to 0.

## Test plan
All scenarios use N=16.
- Clean byte: drive 0xA5 as 8N1 → exactly one `valid` pulse, `data`=0xA5, `frame_err`=0, `busy` low again within 8 clocks of the stop sample.
- Glitch: pull `rx` low for 4 clocks, then high → no `valid`, no `frame_err`, back to IDLE (`busy`=0) by E0+H+1.
- Framing error: send 0x3C with stop bit 0, then hold `rx` low for 40 clocks, then release → one `frame_err` pulse, no `valid`, `data` keeps its previous value, and no further pulses until the next real start bit.
- Back-to-back: send 0x00 and then 0xFF with no idle gap between frames → two `valid` pulses exactly 160 clocks apart, `data` 0x00 then 0xFF.
- Reset mid-frame: assert `rst` for 1 clock during data bit 3 of 0x77, then send 0x5A → all outputs 0 after reset, no byte from the first frame, then one `valid` with `data`=0x5A.
- With `UART_RX_PARITY_EN` defined:
  - send 0x01 with parity bit 0 → `valid` and `parity_err` pulse together, `data`=0x01;
  - send 0x03 with parity bit 0 → `valid` only.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a 2-flop input synchronizer.
// Define UART_RX_PARITY_EN to add an even-parity bit after data bit 7.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic          rx_meta, rx_s;
    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;

    // Metastability guard; idle level is 1 so both flops reset high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n, perr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_n;
            parity_err <= perr_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
            busy      <= (state_n != S_IDLE);
        end
    end

    // Next-state and output decode; cnt restarts on every state change.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        shift_n = shift;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    par_bad_n = rx_s ^ (^shift);
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_n  = par_bad;
`endif
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames in, scoreboard of expected bytes popped on valid.
module tb_uart_rx;

    localparam int unsigned N = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int t_last  = 0;
    int t_prev  = 0;
    logic [8:0] sb[$];   // {parity_err, data}

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each valid pulse.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            logic [8:0] e;
            n_valid++;
            t_prev = t_last;
            t_last = cyc;
            chk("valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("data", 32'(data), 32'(e[7:0]));
                chk("parity_err", 32'(parity_err), 32'(e[8]));
            end
            chk("valid_with_ferr", 32'(frame_err), 32'd0);
        end else if (parity_err !== 1'b0) begin
            chk("perr_without_valid", 32'(parity_err), 32'd0);
        end
        if (frame_err === 1'b1) n_ferr++;
    end

    task automatic bit_time(input logic v);
        rx = v;
        repeat (N) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(par);
`else
        if (par) rx = 1'b1;
`endif
        bit_time(stop);
    endtask

    task automatic send_good(input logic [7:0] b);
        sb.push_back({1'b0, b});
        send_frame(b, ^b, 1'b1);
    endtask

    initial begin
        int v0, f0;
        logic [7:0] pat;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);

        // Clean byte
        v0 = n_valid; f0 = n_ferr;
        send_good(8'hA5);
        #1;
        chk("clean_nvalid", 32'(n_valid - v0), 32'd1);
        chk("clean_nferr", 32'(n_ferr - f0), 32'd0);
        chk("clean_busy", 32'(busy), 32'd0);
        chk("clean_data_hold", 32'(data), 32'hA5);
        repeat (N) @(negedge clk);

        // Glitch: 4 clocks low
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy_during", 32'(busy), 32'd1);
        repeat (9) @(negedge clk);
        chk("glitch_busy_after", 32'(busy), 32'd0);
        repeat (2 * N) @(negedge clk);
        chk("glitch_nvalid", 32'(n_valid - v0), 32'd0);
        chk("glitch_nferr", 32'(n_ferr - f0), 32'd0);

        // Framing error followed by a held-low line
        v0 = n_valid; f0 = n_ferr;
        pat = 8'h3C;
        send_frame(pat, ^pat, 1'b0);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (3 * N) @(negedge clk);
        chk("ferr_nferr", 32'(n_ferr - f0), 32'd1);
        chk("ferr_nvalid", 32'(n_valid - v0), 32'd0);
        chk("ferr_data_kept", 32'(data), 32'hA5);
        chk("ferr_busy", 32'(busy), 32'd0);

        // Back-to-back frames, no idle gap
        v0 = n_valid;
        send_good(8'h00);
        send_good(8'hFF);
        repeat (2 * N) @(negedge clk);
        chk("b2b_nvalid", 32'(n_valid - v0), 32'd2);
        chk("b2b_spacing", 32'(t_last - t_prev), 32'(FRAME_BITS * N));
        chk("b2b_data_last", 32'(data), 32'hFF);

        // Reset during data bit 3 of 0x77
        v0 = n_valid; f0 = n_ferr;
        pat = 8'h77;
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(pat[i]);
        rx = pat[3];
        repeat (N / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data), 32'h00);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_perr", 32'(parity_err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2 * FRAME_BITS * N) @(negedge clk);
        chk("mid_rst_no_byte", 32'(n_valid - v0), 32'd0);
        send_good(8'h5A);
        repeat (2 * N) @(negedge clk);
        chk("mid_rst_nvalid", 32'(n_valid - v0), 32'd1);
        chk("mid_rst_nferr", 32'(n_ferr - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x01 with parity 0 is a mismatch, 0x03 with parity 0 is correct
        v0 = n_valid;
        sb.push_back({1'b1, 8'h01});
        send_frame(8'h01, 1'b0, 1'b1);
        sb.push_back({1'b0, 8'h03});
        send_frame(8'h03, 1'b0, 1'b1);
        repeat (2 * N) @(negedge clk);
        chk("par_nvalid", 32'(n_valid - v0), 32'd2);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
